// File: rtl/par_to_serial_if.sv
// ============================================================================
// Module   : par_to_serial_if
// Purpose  : Word-input handshake and serial-output bundle for par_to_serial.
//            master = word producer / serial consumer, slave = the transmitter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface par_to_serial_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  dataValid;
  logic                  dataReady;
  logic                  serialOut;
  logic                  frameStart;
  logic                  busy;

  modport master (
    output dataIn, dataValid,
    input  dataReady, serialOut, frameStart, busy
  );

  modport slave (
    input  dataIn, dataValid,
    output dataReady, serialOut, frameStart, busy
  );
endinterface

`default_nettype wire

// File: rtl/par_to_serial.sv
// ============================================================================
// Module   : par_to_serial
// Purpose  : Parallel-to-serial transmitter. One-entry holding buffer feeding
//            an MSB-first shifter, frameStart on each frame's MSB, back-to-back
//            frames with no idle gap.
// Options  : PARITY_EN - append one even-parity bit after each frame's LSB.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module par_to_serial #(
  parameter int DATA_WIDTH = 4
) (
  input  logic            fastClk,
  input  logic            reset,     // asynchronous, active-low
  par_to_serial_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t                 state_q,      state_d;
  logic [DATA_WIDTH-1:0]  buf_q,        buf_d;
  logic                   bufFull_q,    bufFull_d;
  logic [DATA_WIDTH-1:0]  shift_q,      shift_d;
  logic [CNT_W-1:0]       bitCnt_q,     bitCnt_d;
  logic                   serial_q,     serial_d;
  logic                   frameStart_q, frameStart_d;
  logic                   busy_q,       busy_d;
`ifdef PARITY_EN
  logic                   parity_q,     parity_d;
`endif

  logic accept;
  logic load;
  logic endFrame;

  // Next-state logic: FSM sequencing, shifter, buffer and registered outputs.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    bufFull_d    = bufFull_q;
    shift_d      = shift_q;
    bitCnt_d     = bitCnt_q;
    serial_d     = serial_q;
    frameStart_d = 1'b0;
    busy_d       = busy_q;
`ifdef PARITY_EN
    parity_d     = parity_q;
`endif
    load         = 1'b0;
    endFrame     = 1'b0;
    accept       = bus.dataValid & ~bufFull_q;

    case (state_q)
      IDLE: begin
        serial_d = 1'b0;
        busy_d   = 1'b0;
        load     = bufFull_q;
      end
      SHIFT: begin
        if (bitCnt_q != '0) begin
          // shift_q[MSB] is the bit currently on the line
          shift_d  = shift_q << 1;
          serial_d = shift_q[DATA_WIDTH-2];
          bitCnt_d = bitCnt_q - 1'b1;
        end else begin
`ifdef PARITY_EN
          state_d  = PARITY;
          serial_d = parity_q;
`else
          endFrame = 1'b1;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: endFrame = 1'b1;
`endif
      default: state_d = IDLE;
    endcase

    // A waiting word chains straight into the next frame; otherwise go quiet.
    if (endFrame) begin
      if (bufFull_q) begin
        load = 1'b1;
      end else begin
        state_d  = IDLE;
        serial_d = 1'b0;
        busy_d   = 1'b0;
      end
    end

    if (load) begin
      shift_d      = buf_q;
      serial_d     = buf_q[DATA_WIDTH-1];
      frameStart_d = 1'b1;
      busy_d       = 1'b1;
      bitCnt_d     = CNT_LAST;
      state_d      = SHIFT;
`ifdef PARITY_EN
      parity_d     = ^buf_q;
`endif
    end

    // Shifter takes the old buffered word before a same-edge accept refills it.
    if (accept) begin
      buf_d = bus.dataIn;
    end
    bufFull_d = accept | (bufFull_q & ~load);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge fastClk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      bufFull_q    <= 1'b0;
      shift_q      <= '0;
      bitCnt_q     <= '0;
      serial_q     <= 1'b0;
      frameStart_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      bufFull_q    <= bufFull_d;
      shift_q      <= shift_d;
      bitCnt_q     <= bitCnt_d;
      serial_q     <= serial_d;
      frameStart_q <= frameStart_d;
      busy_q       <= busy_d;
`ifdef PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.dataReady  = ~bufFull_q;
  assign bus.serialOut  = serial_q;
  assign bus.frameStart = frameStart_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_par_to_serial.sv
// ============================================================================
// Module   : tb_par_to_serial
// Purpose  : Scoreboard bench for par_to_serial (DATA_WIDTH = 4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_par_to_serial;

`ifdef PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic fastClk;
  logic reset;

  par_to_serial_if #(.DATA_WIDTH(4)) bus ();

  par_to_serial #(.DATA_WIDTH(4)) dut (
    .fastClk (fastClk),
    .reset   (reset),
    .bus     (bus)
  );

  initial fastClk = 1'b0;
  always #5 fastClk = ~fastClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line samples: {frameStart, serialOut}
  logic [1:0] exp_q[$];
  int         n_cmp;
  int         n_fail;
  logic       mon_en;
  logic       saw_wait;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hand-derived frame: bits MSB-first, frameStart on the first, optional parity.
  task automatic push_frame(input logic [3:0] bits, input logic par);
    exp_q.push_back({1'b1, bits[3]});
    exp_q.push_back({1'b0, bits[2]});
    exp_q.push_back({1'b0, bits[1]});
    exp_q.push_back({1'b0, bits[0]});
`ifdef PARITY_EN
    exp_q.push_back({1'b0, par});
`else
    if (par === 1'bx) exp_q.push_back(2'b00);  // never taken for hand-given parity
`endif
  endtask

  // Offer a word until accepted; push its expected frame on the accepting edge.
  task automatic send(input logic [3:0] w, input logic par);
    logic r;
    logic accepted;
    accepted = 1'b0;
    bus.dataIn    = w;
    bus.dataValid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      r = bus.dataReady;
      if (!r) saw_wait = 1'b1;
      @(posedge fastClk);
      #1;
      if (r) accepted = 1'b1;
    end
    check("accept", {7'd0, accepted}, 8'd1);
    if (accepted) push_frame(w, par);
    bus.dataValid = 1'b0;
    bus.dataIn    = ~w;
  endtask

  task automatic measure_run(output int len);
    len = 0;
    for (int i = 0; i < 40 && !bus.busy; i++) @(negedge fastClk);
    while (bus.busy && len < 100) begin
      len++;
      @(negedge fastClk);
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge fastClk);
      if (!bus.busy && exp_q.size() == 0 && bus.dataReady) done = 1'b1;
    end
    check("wait_idle", {7'd0, done}, 8'd1);
    repeat (2) @(negedge fastClk);
  endtask

  initial begin
    int run;
    logic seen;
    n_cmp         = 0;
    n_fail        = 0;
    mon_en        = 1'b0;
    saw_wait      = 1'b0;
    reset         = 1'b0;
    bus.dataIn    = '0;
    bus.dataValid = 1'b0;

    // Monitor: pop one expected sample per busy cycle; idle line must be 0.
    fork
      forever begin
        @(negedge fastClk);
        if (mon_en) begin
          if (bus.busy) begin
            if (exp_q.size() == 0) begin
              check("unexpected_bit", {6'd0, bus.frameStart, bus.serialOut}, 8'hEE);
            end else begin
              logic [1:0] e;
              e = exp_q.pop_front();
              check("frame_bit", {6'd0, bus.frameStart, bus.serialOut}, {6'd0, e});
            end
          end else begin
            check("idle_line", {6'd0, bus.frameStart, bus.serialOut}, 8'd0);
          end
        end
      end
    join_none

    // Reset state
    @(posedge fastClk);
    #1;
    check("rst_serial", {7'd0, bus.serialOut}, 8'd0);
    check("rst_fs",     {7'd0, bus.frameStart}, 8'd0);
    check("rst_busy",   {7'd0, bus.busy}, 8'd0);
    check("rst_ready",  {7'd0, bus.dataReady}, 8'd1);
    @(posedge fastClk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge fastClk);
    #1;

    // 1: single word, one-cycle latency
    send(4'b1011, 1'b1);
    @(negedge fastClk);
    check("t1_lat_idle", {7'd0, bus.busy}, 8'd0);
    @(negedge fastClk);
    check("t1_lat_fs", {7'd0, bus.frameStart}, 8'd1);
    wait_idle();

    // 2: two words back-to-back, no gap
    fork
      begin send(4'hA, 1'b0); send(4'h5, 1'b0); end
      measure_run(run);
    join
    check("t2_run", run[7:0], 8'(2 * FLEN));
    wait_idle();

    // 3: three words continuously offered; buffer fills and stalls upstream
    @(posedge fastClk);
    #1;
    saw_wait = 1'b0;
    fork
      begin send(4'h1, 1'b1); send(4'h2, 1'b1); send(4'h3, 1'b0); end
      measure_run(run);
    join
    check("t3_run", run[7:0], 8'(3 * FLEN));
    check("t3_ready_dropped", {7'd0, saw_wait}, 8'd1);
    wait_idle();

    // 4: asynchronous reset during the second bit of 4'hC
    @(posedge fastClk);
    #1;
    send(4'hC, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge fastClk);
      if (bus.frameStart) seen = 1'b1;
    end
    check("t4_fs_seen", {7'd0, seen}, 8'd1);
    @(posedge fastClk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("t4_serial", {7'd0, bus.serialOut}, 8'd0);
    check("t4_busy",   {7'd0, bus.busy}, 8'd0);
    check("t4_fs",     {7'd0, bus.frameStart}, 8'd0);
    exp_q.delete();
    repeat (2) @(posedge fastClk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    check("t4_ready", {7'd0, bus.dataReady}, 8'd1);
    repeat (8) @(negedge fastClk);

`ifdef PARITY_EN
    // 5: parity frames, 5 cycles each
    @(posedge fastClk);
    #1;
    fork
      begin send(4'b0111, 1'b1); send(4'b0011, 1'b0); end
      measure_run(run);
    join
    check("t5_run", run[7:0], 8'd10);
    wait_idle();
`endif

    // 6: dataIn toggling without dataValid is ignored
    @(posedge fastClk);
    #1;
    for (int i = 0; i < 10; i++) begin
      bus.dataIn = 4'($urandom);
      @(posedge fastClk);
      #1;
      check("t6_ready", {7'd0, bus.dataReady}, 8'd1);
    end
    repeat (3) @(negedge fastClk);

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
